viterbi_tbu_lifo: RTL and testbench
===================================

Name: viterbi_tbu_lifo

Overview:
Parametrised Viterbi traceback unit for the convolutional decoder datapath. It sits between the survivor (decision) memory and the decoded-bit sink.
- Consumes one NS-bit decision vector per cycle, newest first, starting from a supplied best state.
- Runs a configurable training traceback (bits discarded), then a decode region.
- A LIFO reverses the decode-region bits so they leave in chronological order over a valid/ready handshake.

Parameters:
- K, 4: constraint length. SW = K-1 state bits, NS = 2**SW trellis states.
- TB_LEN, 16: training traceback steps per pass. Bits discarded. 0 is legal.
- DEC_LEN, 8: decode steps per pass. Bits emitted. Must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous abort. Returns to IDLE and empties the LIFO.
- start_valid  in  1  request to start a traceback pass
- start_state  in  SW  initial trellis state, captured on start handshake
- start_ready  out  1  high only in IDLE
- dec_valid  in  1  decision vector valid
- dec_vec  in  NS  survivor bits, one per state, newest time step first
- dec_ready  out  1  high only in TRACE
- out_valid  out  1  decoded bit valid
- out_bit  out  1  decoded bit, chronological order
- out_last  out  1  marks the final (newest) bit of the pass
- out_ready  in  1  sink accepts bit
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (rst=0, async): FSM=IDLE, state reg=0, step counter=0, LIFO empty.
- Output reset values: start_ready=1, dec_ready=0, out_valid=0, out_bit=0, out_last=0, busy=0.
- FSM states: IDLE, TRACE, DRAIN.
- IDLE:
  - start_valid & start_ready: load state reg s <= start_state, step=0, go to TRACE next cycle.
- TRACE:
  - dec_ready=1. Each cycle with dec_valid, one step executes.
  - Decoded bit b = s[SW-1].
  - Next state s <= {s[SW-2:0], dec_vec[s]}.
  - If step ≥ TB_LEN, push b into the LIFO.
  - step++.
  - The step with step == TB_LEN+DEC_LEN-1 goes to DRAIN.
  - dec_valid=0 stalls; nothing changes.
- DRAIN:
  - out_valid registered, asserted the first cycle in DRAIN.
  - out_bit = LIFO top.
  - A pop occurs on out_valid & out_ready; the next bit is presented the following cycle, so throughput is 1 bit/cycle.
  - out_last=1 with the final bit, when the LIFO holds 1 entry.
  - Pop of the last bit: out_valid deasserts next cycle, FSM goes to IDLE.
  - out_valid & !out_ready: out_bit and out_last hold stable.
- Latency: first out_valid is exactly 1 cycle after the final accepted dec_vec. A full pass with no stalls takes 1 + TB_LEN + DEC_LEN + DEC_LEN cycles.
- Ordering: pushes occur newest-to-oldest. Pops therefore emit oldest first.
- flush=1 (any state): next cycle IDLE, LIFO empty, out_valid=0, counter=0. flush has priority over all handshakes that cycle.
- start_valid outside IDLE is ignored. There is no queuing.
- LIFO:
  - Depth exactly DEC_LEN.
  - Push when full cannot occur by construction; assert in simulation.
  - Pop when empty is also illegal; assert.
- Widths: step counter is $clog2(TB_LEN+DEC_LEN+1) bits. Index dec_vec with the SW-bit state, unsigned.
- Reset mid-pass: immediate IDLE, all outputs at reset values. No partial output is emitted afterwards.

Decomposition:
- Package viterbi_pkg:
  - Enum tbu_state_e {IDLE, TRACE, DRAIN}.
  - Function tb_next(s, v) returning {s[SW-2:0], v[s]}.
  - Function tb_bit(s) returning s[SW-1].
  - Shared defaults K=4, TB_LEN=16, DEC_LEN=8.
- Sub-module tbu_lifo:
  - Parameter DEPTH.
  - Bit storage, SP pointer, push/pop/clr, top, empty, count_is_one.
  - Async active-low rst.

Test Plan:
1. K=4, TB_LEN=2, DEC_LEN=4; start_state=3'b101; six all-zero dec_vec → out_bit sequence 0,0,0,1; out_last on the 4th bit; first out_valid 1 cycle after the 6th vector.
2. Defaults; start_state=0; 24 all-ones dec_vec → states 000→001→011→111 and hold. Out bits: 8×1, out_last on the 8th.
3. Defaults; random start_state and vectors; dec_valid randomly gapped 50% → output matches a golden model bit-for-bit. No step is taken on a gapped cycle.
4. Scenario 1 with out_ready low for 5 cycles at bit 2 → out_bit and out_last stable while stalled; sequence unchanged; busy held.
5. flush asserted after 10 vectors of a pass, then a new pass with start_state=3'b011 → no residual output; new pass output matches the model.
6. rst pulsed low during DRAIN → out_valid=0 and start_ready=1 immediately. The next pass decodes correctly.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi traceback unit.
//   tbu_state_e : traceback FSM states
//   tb_next     : one traceback step, {s[SW-2:0], v[s]}
//   tb_bit      : decoded bit of a state, s[SW-1]
// The helpers work on MAX_SW/MAX_NS-wide operands with the live state width
// passed in, so one package serves any K up to MAX_SW+1.
package viterbi_pkg;

  localparam int K_DEF       = 4;
  localparam int TB_LEN_DEF  = 16;
  localparam int DEC_LEN_DEF = 8;

  localparam int MAX_SW = 8;
  localparam int MAX_NS = 1 << MAX_SW;

  typedef enum logic [1:0] {IDLE, TRACE, DRAIN} tbu_state_e;

  function automatic logic [MAX_SW-1:0] tb_next(input logic [MAX_SW-1:0] s,
                                                input logic [MAX_NS-1:0] v,
                                                input int unsigned       sw);
    logic [MAX_SW-1:0] mask;
    mask = (MAX_SW'(1) << sw) - MAX_SW'(1);
    return ((s << 1) | MAX_SW'(v[s])) & mask;
  endfunction

  function automatic logic tb_bit(input logic [MAX_SW-1:0] s,
                                  input int unsigned       sw);
    return |(s & (MAX_SW'(1) << (sw - 1)));
  endfunction

endpackage

// File: rtl/viterbi_tbu_lifo_lifo.sv
// Bit LIFO used to reverse traceback order.
//   clk, rst        : clock, async active-low reset
//   push, din       : push din on top
//   pop             : drop the top entry
//   clr             : synchronous empty, wins over push/pop
//   top             : current top entry
//   empty           : no entries
//   count_is_one    : exactly one entry left
// Stored as a shift register with the top at bit 0, so no pointer indexing.
module tbu_lifo #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic clr,
  input  logic din,
  output logic top,
  output logic empty,
  output logic count_is_one
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [CW-1:0]    sp;
  logic             full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
      sp  <= '0;
    end else if (clr) begin
      mem <= '0;
      sp  <= '0;
    end else if (push) begin
      mem <= DEPTH'({mem, din});
      sp  <= sp + CW'(1);
    end else if (pop) begin
      mem <= mem >> 1;
      sp  <= sp - CW'(1);
    end
  end

  assign top          = mem[0];
  assign empty        = (sp == '0);
  assign count_is_one = (sp == CW'(1));
  assign full         = (sp == CW'(DEPTH));

  a_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && !clr && full));
  a_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop && !clr && empty));

endmodule

// File: rtl/viterbi_tbu_lifo.sv
// Viterbi traceback unit with LIFO re-ordering of decoded bits.
//   clk, rst                 : clock, async active-low reset
//   flush                    : synchronous abort to IDLE, empties the LIFO
//   start_valid/ready/state  : start a pass from a given best state
//   dec_valid/ready/vec      : one survivor vector per step, newest first
//   out_valid/ready/bit/last : decoded bits, oldest first, last marks newest
//   busy                     : FSM not in IDLE
// K must not exceed MAX_SW+1 of the package helpers.
module viterbi_tbu_lifo
  import viterbi_pkg::*;
#(
  parameter int K       = K_DEF,
  parameter int TB_LEN  = TB_LEN_DEF,
  parameter int DEC_LEN = DEC_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start_valid,
  input  logic [K-2:0]          start_state,
  output logic                  start_ready,
  input  logic                  dec_valid,
  input  logic [(1<<(K-1))-1:0] dec_vec,
  output logic                  dec_ready,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int SW = K - 1;
  localparam int CW = $clog2(TB_LEN + DEC_LEN + 1);
  localparam logic [CW-1:0] TB_C   = CW'(TB_LEN);
  localparam logic [CW-1:0] LAST_C = CW'(TB_LEN + DEC_LEN - 1);

  tbu_state_e    state, state_n;
  logic [SW-1:0] s, s_n;
  logic [CW-1:0] step, step_n;
  logic          push, pop, bit_d;
  logic          lifo_top, lifo_empty, lifo_one;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s     <= '0;
      step  <= '0;
    end else begin
      state <= state_n;
      s     <= s_n;
      step  <= step_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    step_n  = step;
    push    = 1'b0;
    pop     = 1'b0;
    bit_d   = tb_bit(MAX_SW'(s), SW);
    case (state)
      IDLE: if (start_valid) begin
        s_n     = start_state;
        step_n  = '0;
        state_n = TRACE;
      end
      TRACE: if (dec_valid) begin
        s_n    = SW'(tb_next(MAX_SW'(s), MAX_NS'(dec_vec), SW));
        // Training steps walk the trellis but their bits are discarded.
        push   = (step >= TB_C);
        step_n = step + CW'(1);
        if (step == LAST_C) state_n = DRAIN;
      end
      DRAIN: if (out_valid && out_ready) begin
        pop = 1'b1;
        if (lifo_one) begin
          state_n = IDLE;
          step_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort beats every handshake in the same cycle.
    if (flush) begin
      state_n = IDLE;
      step_n  = '0;
      push    = 1'b0;
      pop     = 1'b0;
    end
  end

  tbu_lifo #(.DEPTH(DEC_LEN)) u_lifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clr          (flush),
    .din          (bit_d),
    .top          (lifo_top),
    .empty        (lifo_empty),
    .count_is_one (lifo_one)
  );

  // All outputs decode registered state, so they are glitch-free and the
  // first bit appears the cycle after the final step.
  assign start_ready = (state == IDLE);
  assign dec_ready   = (state == TRACE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == DRAIN) && !lifo_empty;
  assign out_bit     = out_valid & lifo_top;
  assign out_last    = out_valid & lifo_one;

endmodule

// File: tb/tb_viterbi_tbu_lifo.sv
module tb_viterbi_tbu_lifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush       [2];
  logic       start_valid [2];
  logic [2:0] start_state [2];
  logic       start_ready [2];
  logic       dec_valid   [2];
  logic [7:0] dec_vec     [2];
  logic       dec_ready   [2];
  logic       out_valid   [2];
  logic       out_bit     [2];
  logic       out_last    [2];
  logic       out_ready   [2];
  logic       busy        [2];

  always #5 clk = ~clk;

  // Instance 0: short pass (TB_LEN=2, DEC_LEN=4); instance 1: defaults.
  viterbi_tbu_lifo #(.K(4), .TB_LEN(2), .DEC_LEN(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush[0]),
    .start_valid(start_valid[0]), .start_state(start_state[0]), .start_ready(start_ready[0]),
    .dec_valid(dec_valid[0]), .dec_vec(dec_vec[0]), .dec_ready(dec_ready[0]),
    .out_valid(out_valid[0]), .out_bit(out_bit[0]), .out_last(out_last[0]),
    .out_ready(out_ready[0]), .busy(busy[0])
  );

  viterbi_tbu_lifo #(.K(4), .TB_LEN(16), .DEC_LEN(8)) u1 (
    .clk(clk), .rst(rst), .flush(flush[1]),
    .start_valid(start_valid[1]), .start_state(start_state[1]), .start_ready(start_ready[1]),
    .dec_valid(dec_valid[1]), .dec_vec(dec_vec[1]), .dec_ready(dec_ready[1]),
    .out_valid(out_valid[1]), .out_bit(out_bit[1]), .out_last(out_last[1]),
    .out_ready(out_ready[1]), .busy(busy[1])
  );

  int checks = 0;
  int passed = 0;
  logic [7:0] vq[$];

  typedef struct {
    int         d;
    logic [2:0] st;
    logic [7:0] fill;
    logic [7:0] exp;   // bit j = j-th emitted bit
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int tbl_of(input int d); return d ? 16 : 2; endfunction
  function automatic int dl_of(input int d);  return d ? 8 : 4;  endfunction

  // Golden traceback over vq; returns bits in emission (chronological) order.
  function automatic logic [7:0] model(input logic [2:0] st, input int tbl, input int dl);
    logic [2:0] s;
    logic [7:0] p, r, v;
    s = st; p = '0; r = '0;
    for (int i = 0; i < tbl + dl; i++) begin
      if (i >= tbl) p[i-tbl] = s[2];
      v = vq[i];
      s = {s[1:0], v[s]};
    end
    for (int j = 0; j < dl; j++) r[j] = p[dl-1-j];
    return r;
  endfunction

  task automatic fill_q(input int n, input logic [7:0] f, input bit rnd);
    vq.delete();
    for (int i = 0; i < n; i++) vq.push_back(rnd ? 8'($urandom) : f);
  endtask

  task automatic do_start(input int d, input logic [2:0] st);
    chk("start_ready_idle", start_ready[d], 1);
    start_valid[d] = 1'b1;
    start_state[d] = st;
    @(posedge clk); #1;
    start_valid[d] = 1'b0;
    chk("dec_ready_trace", dec_ready[d], 1);
    chk("busy_trace", busy[d], 1);
  endtask

  task automatic do_feed(input int d, input int n, input int gap_pct, input bit chk_lat);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 2000) begin
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) dec_valid[d] = 1'b0;
      else begin
        dec_valid[d] = 1'b1;
        dec_vec[d]   = vq[i];
      end
      @(posedge clk); #1;
      cyc++;
      if (dec_valid[d]) i++;
    end
    dec_valid[d] = 1'b0;
    chk("feed_done", i, n);
    if (chk_lat) chk("first_valid_latency", out_valid[d], 1);
  endtask

  task automatic do_drain(input int d, input logic [7:0] exp, input int stall_at,
                          input int stall_len, input int ntake);
    int dl = dl_of(d);
    for (int j = 0; j < ntake; j++) begin
      int w = 0;
      while (!out_valid[d] && w < 20) begin @(posedge clk); #1; w++; end
      if (!out_valid[d]) begin chk("out_valid_wait", out_valid[d], 1); break; end
      if (j == stall_at) begin
        logic b0, l0;
        b0 = out_bit[d]; l0 = out_last[d];
        out_ready[d] = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          chk("stall_bit", out_bit[d], b0);
          chk("stall_last", out_last[d], l0);
          chk("stall_busy", busy[d], 1);
          chk("stall_valid", out_valid[d], 1);
        end
        out_ready[d] = 1'b1;
      end
      chk($sformatf("bit%0d", j), out_bit[d], exp[j]);
      chk($sformatf("last%0d", j), out_last[d], (j == dl - 1));
      @(posedge clk); #1;
    end
    if (ntake == dl) begin
      chk("valid_after_pass", out_valid[d], 0);
      chk("start_ready_after_pass", start_ready[d], 1);
      chk("busy_after_pass", busy[d], 0);
    end
  endtask

  task automatic run_pass(input int d, input logic [2:0] st, input int gap,
                          input int stall_at, input int stall_len, input logic [7:0] exp);
    do_start(d, st);
    do_feed(d, tbl_of(d) + dl_of(d), gap, 1'b1);
    do_drain(d, exp, stall_at, stall_len, dl_of(d));
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 3'b101, 8'h00, 8'b0000_1000};
    tbl[1] = '{1, 3'b000, 8'hff, 8'hff};
    tbl[2] = '{0, 3'b000, 8'hff, 8'b0000_0111};
    tbl[3] = '{0, 3'b111, 8'h00, 8'b0000_1000};
    tbl[4] = '{0, 3'b000, 8'h55, 8'b0000_0101};
    tbl[5] = '{1, 3'b101, 8'h00, 8'h00};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 0; start_valid[d] = 0; start_state[d] = '0;
      dec_valid[d] = 0; dec_vec[d] = '0; out_ready[d] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_start_ready", start_ready[d], 1);
      chk("rst_dec_ready", dec_ready[d], 0);
      chk("rst_out_valid", out_valid[d], 0);
      chk("rst_out_bit", out_bit[d], 0);
      chk("rst_out_last", out_last[d], 0);
      chk("rst_busy", busy[d], 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed table of constant-vector passes.
    for (int r = 0; r < 6; r++) begin
      fill_q(tbl_of(tbl[r].d) + dl_of(tbl[r].d), tbl[r].fill, 1'b0);
      run_pass(tbl[r].d, tbl[r].st, 0, -1, 0, tbl[r].exp);
    end

    // Random vectors with 50% dec_valid gaps against the model.
    for (int p = 0; p < 3; p++) begin
      logic [2:0] st;
      st = 3'($urandom_range(0, 7));
      fill_q(24, 8'h00, 1'b1);
      run_pass(1, st, 50, -1, 0, model(st, 16, 8));
    end

    // Sink stall on the second bit of the short pass.
    fill_q(6, 8'h00, 1'b0);
    run_pass(0, 3'b101, 0, 1, 5, 8'b0000_1000);

    // Flush beats a start request in IDLE.
    start_valid[0] = 1'b1; flush[0] = 1'b1;
    @(posedge clk); #1;
    start_valid[0] = 1'b0; flush[0] = 1'b0;
    chk("flush_vs_start_busy", busy[0], 0);

    // Flush mid-trace, with a vector offered in the same cycle.
    fill_q(24, 8'h00, 1'b1);
    do_start(1, 3'($urandom_range(0, 7)));
    do_feed(1, 10, 0, 1'b0);
    flush[1] = 1'b1; dec_valid[1] = 1'b1;
    @(posedge clk); #1;
    flush[1] = 1'b0; dec_valid[1] = 1'b0;
    chk("flush_start_ready", start_ready[1], 1);
    chk("flush_busy", busy[1], 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("flush_no_residual", out_valid[1], 0);
    end
    fill_q(24, 8'h00, 1'b1);
    run_pass(1, 3'b011, 0, -1, 0, model(3'b011, 16, 8));

    // Async reset during drain, then a clean pass.
    begin
      logic [2:0] st;
      st = 3'($urandom_range(0, 7));
      fill_q(24, 8'h00, 1'b1);
      do_start(1, st);
      do_feed(1, 24, 0, 1'b1);
      do_drain(1, model(st, 16, 8), -1, 0, 2);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid[1], 0);
      chk("rst_mid_start_ready", start_ready[1], 1);
      chk("rst_mid_busy", busy[1], 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_no_residual", out_valid[1], 0);
      st = 3'($urandom_range(0, 7));
      fill_q(24, 8'h00, 1'b1);
      run_pass(1, st, 0, -1, 0, model(st, 16, 8));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
